// File: rtl/hazard_scoreboard_pkg.sv
// Shared control encodings and scoreboard types for the ID-stage hazard logic.
package hazard_scoreboard_pkg;

   localparam int NUM_REGS = 32;

   localparam logic [1:0] BRANCH_NONE = 2'd0;
   localparam logic [1:0] BRANCH_BEQ  = 2'd1;
   localparam logic [1:0] BRANCH_BNE  = 2'd2;

   localparam logic [1:0] JUMP_NONE   = 2'd0;
   localparam logic [1:0] JUMP_J      = 2'd1;
   localparam logic [1:0] JUMP_REG    = 2'd2;

   localparam logic [1:0] REGSRC_ALU     = 2'd0;
   localparam logic [1:0] REGSRC_DMEM    = 2'd1;
   localparam logic [1:0] REGSRC_PCPLUS4 = 2'd2;

   localparam logic [1:0] AGE_EX  = 2'd1;
   localparam logic [1:0] AGE_MEM = 2'd2;
   localparam logic [1:0] AGE_WB  = 2'd3;

   typedef struct packed {
      logic       valid;
      logic [1:0] age;
      logic [1:0] kind;
   } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage instruction fields in, front-end stall controls out.
interface hazard_scoreboard_if #(parameter int CNT_W = 16);
   logic             ID_valid;
   logic [4:0]       ID_rs;
   logic [4:0]       ID_rt;
   logic             ID_useRs;
   logic             ID_useRt;
   logic [1:0]       ID_Branch;
   logic [1:0]       ID_Jump;
   logic             ID_RegWrite;
   logic [1:0]       ID_RegSrc;
   logic [4:0]       ID_WriteReg;
   logic             stall;
   logic             PC_write;
   logic             IFID_write;
   logic             IDEX_bubble;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output ID_valid, ID_rs, ID_rt, ID_useRs, ID_useRt, ID_Branch, ID_Jump,
             ID_RegWrite, ID_RegSrc, ID_WriteReg,
      input  stall, PC_write, IFID_write, IDEX_bubble, stall_count
   );

   modport slave (
      input  ID_valid, ID_rs, ID_rt, ID_useRs, ID_useRt, ID_Branch, ID_Jump,
             ID_RegWrite, ID_RegSrc, ID_WriteReg,
      output stall, PC_write, IFID_write, IDEX_bubble, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard_check.sv
// Per-operand hazard test: can the bypass network supply register i_r this cycle?
module hazard_sb_check
   import hazard_scoreboard_pkg::*;
(
   input  sb_entry_t  i_entry,
   input  logic       i_use_at_id,
   input  logic       i_use,
   input  logic [4:0] i_r,
   output logic       o_hazard
);

   logic [1:0] w_kind;

   // The spare kind encoding behaves like an ALU producer.
   assign w_kind = (i_entry.kind == 2'b11) ? REGSRC_ALU : i_entry.kind;

   always_comb begin
      // NOTE: assign the default first so no path leaves o_hazard unassigned (no latch).
      o_hazard = 1'b0;
      if (i_use && (i_r != 5'd0) && i_entry.valid) begin
         if (i_use_at_id)
            o_hazard = ((i_entry.age == AGE_EX)  && ((w_kind == REGSRC_ALU) || (w_kind == REGSRC_DMEM))) ||
                       ((i_entry.age == AGE_MEM) && (w_kind == REGSRC_DMEM));
         else
            o_hazard = (i_entry.age == AGE_EX) && (w_kind == REGSRC_DMEM);
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes in EX/MEM/WB and stalls the front end when
// an ID operand cannot be forwarded; also counts stalled cycles.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic               clk,
   input  logic               rst,
   hazard_scoreboard_if.slave sb_if
);

   sb_entry_t        r_sb      [NUM_REGS];
   sb_entry_t        w_sb_next [NUM_REGS];
   logic [CNT_W-1:0] r_stall_count;
   logic             w_use_at_id;
   logic             w_haz_rs;
   logic             w_haz_rt;
   logic             w_stall;
   logic             w_issue;

   assign w_use_at_id = (sb_if.ID_Branch != BRANCH_NONE) || (sb_if.ID_Jump == JUMP_REG);

   hazard_sb_check u_chk_rs (
      .i_entry     (r_sb[sb_if.ID_rs]),
      .i_use_at_id (w_use_at_id),
      .i_use       (sb_if.ID_useRs),
      .i_r         (sb_if.ID_rs),
      .o_hazard    (w_haz_rs)
   );

   hazard_sb_check u_chk_rt (
      .i_entry     (r_sb[sb_if.ID_rt]),
      .i_use_at_id (w_use_at_id),
      .i_use       (sb_if.ID_useRt),
      .i_r         (sb_if.ID_rt),
      .o_hazard    (w_haz_rt)
   );

   assign w_stall = sb_if.ID_valid && (w_haz_rs || w_haz_rt);
   assign w_issue = sb_if.ID_valid && !w_stall && sb_if.ID_RegWrite && (sb_if.ID_WriteReg != 5'd0);

   // Aging runs every edge: a stall only inserts a bubble, later stages keep moving.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         w_sb_next[i] = r_sb[i];
         if (r_sb[i].valid) begin
            if (r_sb[i].age == AGE_WB)
               w_sb_next[i].valid = 1'b0;
            else
               w_sb_next[i].age = r_sb[i].age + 2'd1;
         end
      end
      // The youngest producer shadows any older record for the same register.
      if (w_issue)
         w_sb_next[sb_if.ID_WriteReg] = '{valid: 1'b1, age: AGE_EX, kind: sb_if.ID_RegSrc};
      w_sb_next[0] = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the scoreboard array is reset in full; stale records after reset would cause false stalls.
         for (int i = 0; i < NUM_REGS; i++)
            r_sb[i] <= '0;
         r_stall_count <= '0;
      end else begin
         // NOTE: non-blocking updates so every entry ages from the same pre-edge snapshot.
         r_sb <= w_sb_next;
         if (w_stall)
            r_stall_count <= r_stall_count + 1'b1;
      end
   end

   assign sb_if.stall       = w_stall;
   assign sb_if.PC_write    = !w_stall;
   assign sb_if.IFID_write  = !w_stall;
   assign sb_if.IDEX_bubble = w_stall;
   assign sb_if.stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: expected stall/counter values are queued per driven cycle and
// compared at the following falling edge.
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   localparam int CNT_W = 4;

   typedef struct {
      logic             stall;
      logic [CNT_W-1:0] count;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   exp_t exp_q[$];
   logic [CNT_W-1:0] exp_cnt;

   hazard_scoreboard_if #(.CNT_W(CNT_W)) sb_if ();

   hazard_scoreboard #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .sb_if (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [1:0] br,
                        input logic [1:0] jmp, input logic rw, input logic [1:0] src,
                        input logic [4:0] wr, input logic exp_stall);
      exp_t e;
      sb_if.ID_valid    = v;
      sb_if.ID_rs       = rs;
      sb_if.ID_rt       = rt;
      sb_if.ID_useRs    = urs;
      sb_if.ID_useRt    = urt;
      sb_if.ID_Branch   = br;
      sb_if.ID_Jump     = jmp;
      sb_if.ID_RegWrite = rw;
      sb_if.ID_RegSrc   = src;
      sb_if.ID_WriteReg = wr;
      e.stall = exp_stall;
      e.count = exp_cnt;
      exp_q.push_back(e);
      if (exp_stall) exp_cnt = exp_cnt + 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      chk("stall",       32'(sb_if.stall),       32'(e.stall));
      chk("pc_write",    32'(sb_if.PC_write),    32'(!e.stall));
      chk("ifid_write",  32'(sb_if.IFID_write),  32'(!e.stall));
      chk("idex_bubble", 32'(sb_if.IDEX_bubble), 32'(e.stall));
      chk("stall_count", 32'(sb_if.stall_count), 32'(e.count));
      @(posedge clk);
      #1;
   endtask

   task automatic lw(input logic [4:0] rd, input logic s);
      cycle(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, BRANCH_NONE, JUMP_NONE, 1'b1, REGSRC_DMEM, rd, s);
   endtask

   task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt, input logic s);
      cycle(1'b1, rs, rt, 1'b1, 1'b1, BRANCH_NONE, JUMP_NONE, 1'b1, REGSRC_ALU, rd, s);
   endtask

   task automatic beq(input logic [4:0] rs, input logic [4:0] rt, input logic s);
      cycle(1'b1, rs, rt, 1'b1, 1'b1, BRANCH_BEQ, JUMP_NONE, 1'b0, REGSRC_ALU, 5'd0, s);
   endtask

   task automatic jr(input logic [4:0] rs, input logic s);
      cycle(1'b1, rs, 5'd0, 1'b1, 1'b0, BRANCH_NONE, JUMP_REG, 1'b0, REGSRC_ALU, 5'd0, s);
   endtask

   task automatic nop();
      cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, BRANCH_NONE, JUMP_NONE, 1'b0, REGSRC_ALU, 5'd0, 1'b0);
   endtask

   task automatic flush();
      repeat (3) nop();
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      exp_cnt = '0;
      rst     = 1'b1;
      sb_if.ID_valid = 1'b0; sb_if.ID_rs = '0; sb_if.ID_rt = '0;
      sb_if.ID_useRs = 1'b0; sb_if.ID_useRt = 1'b0;
      sb_if.ID_Branch = BRANCH_NONE; sb_if.ID_Jump = JUMP_NONE;
      sb_if.ID_RegWrite = 1'b0; sb_if.ID_RegSrc = REGSRC_ALU; sb_if.ID_WriteReg = '0;
      #1;
      chk("rst_stall",       32'(sb_if.stall),       32'd0);
      chk("rst_pc_write",    32'(sb_if.PC_write),    32'd1);
      chk("rst_ifid_write",  32'(sb_if.IFID_write),  32'd1);
      chk("rst_idex_bubble", 32'(sb_if.IDEX_bubble), 32'd0);
      chk("rst_stall_count", 32'(sb_if.stall_count), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // lw $2; beq $2,$3: two stalls, beq issues on the third cycle
      lw(5'd2, 1'b0);
      beq(5'd2, 5'd3, 1'b1);
      beq(5'd2, 5'd3, 1'b1);
      beq(5'd2, 5'd3, 1'b0);
      flush();

      // add $4; jr $4 -> one stall; with a nop between -> none
      alu(5'd4, 5'd0, 5'd0, 1'b0);
      jr(5'd4, 1'b1);
      jr(5'd4, 1'b0);
      flush();
      alu(5'd4, 5'd0, 5'd0, 1'b0);
      nop();
      jr(5'd4, 1'b0);
      flush();

      // load-use on an ALU op; then jal/jr $31 never stalls
      lw(5'd5, 1'b0);
      alu(5'd6, 5'd5, 5'd7, 1'b1);
      alu(5'd6, 5'd5, 5'd7, 1'b0);
      cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, BRANCH_NONE, JUMP_J, 1'b1, REGSRC_PCPLUS4, 5'd31, 1'b0);
      jr(5'd31, 1'b0);
      flush();

      // writes to $0 are never recorded
      lw(5'd0, 1'b0);
      beq(5'd0, 5'd0, 1'b0);
      chk("entry0_valid", 32'(dut.r_sb[0].valid), 32'd0);
      flush();

      // shadowing: lw $8; addi $8,$0; beq $8 -> one stall from the addi
      lw(5'd8, 1'b0);
      alu(5'd8, 5'd0, 5'd0, 1'b0);
      beq(5'd8, 5'd0, 1'b1);
      beq(5'd8, 5'd0, 1'b0);
      flush();

      // shadowing the other way: a newer load replaces an ALU record
      alu(5'd10, 5'd0, 5'd0, 1'b0);
      lw(5'd10, 1'b0);
      beq(5'd10, 5'd0, 1'b1);
      beq(5'd10, 5'd0, 1'b1);
      beq(5'd10, 5'd0, 1'b0);
      flush();

      // rs and rt both hazardous: still one stall per cycle
      lw(5'd11, 1'b0);
      beq(5'd11, 5'd11, 1'b1);
      beq(5'd11, 5'd11, 1'b1);
      beq(5'd11, 5'd11, 1'b0);
      flush();

      // a bubble in ID never stalls, even with a live dependency
      lw(5'd15, 1'b0);
      cycle(1'b0, 5'd15, 5'd15, 1'b1, 1'b1, BRANCH_BEQ, JUMP_NONE, 1'b0, REGSRC_ALU, 5'd0, 1'b0);
      flush();

      // enough further stalls to wrap the 4-bit counter
      repeat (4) begin
         lw(5'd14, 1'b0);
         beq(5'd14, 5'd0, 1'b1);
         beq(5'd14, 5'd0, 1'b1);
         beq(5'd14, 5'd0, 1'b0);
      end
      flush();

      // asynchronous reset while a load record sits in EX
      lw(5'd20, 1'b0);
      sb_if.ID_valid = 1'b1; sb_if.ID_rs = 5'd20; sb_if.ID_rt = 5'd0;
      sb_if.ID_useRs = 1'b1; sb_if.ID_useRt = 1'b1;
      sb_if.ID_Branch = BRANCH_BEQ; sb_if.ID_Jump = JUMP_NONE;
      sb_if.ID_RegWrite = 1'b0; sb_if.ID_RegSrc = REGSRC_ALU; sb_if.ID_WriteReg = 5'd0;
      @(negedge clk);
      chk("pre_rst_stall", 32'(sb_if.stall), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_stall",       32'(sb_if.stall),       32'd0);
      chk("mid_rst_pc_write",    32'(sb_if.PC_write),    32'd1);
      chk("mid_rst_idex_bubble", 32'(sb_if.IDEX_bubble), 32'd0);
      chk("mid_rst_stall_count", 32'(sb_if.stall_count), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_cnt = '0;
      beq(5'd20, 5'd0, 1'b0);
      nop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

ID-stage hazard scoreboard that decides when the ID-stage and EX-stage bypass networks cannot supply an operand, and stalls the front end. It sits beside the ID-stage forwarding logic, between the IF/ID and ID/EX pipeline registers. It keeps a per-register record of every in-flight write in EX, MEM and WB, and emits PC/IF-ID hold and ID/EX bubble controls. It also counts stall cycles for performance monitoring.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle performance counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ID_valid  in  1  IF/ID holds a real instruction (0 = bubble/flushed)
- ID_rs  in  5  source register 1 of ID instruction
- ID_rt  in  5  source register 2 of ID instruction
- ID_useRs  in  1  ID instruction reads rs
- ID_useRt  in  1  ID instruction reads rt
- ID_Branch  in  2  branch type; BRANCH_NONE = not a branch
- ID_Jump  in  2  jump type; JUMP_REG = jr/jalr
- ID_RegWrite  in  1  ID instruction writes a register
- ID_RegSrc  in  2  writeback source: REGSRC_ALU, REGSRC_DMEM or REGSRC_PCPLUS4
- ID_WriteReg  in  5  destination register of ID instruction
- stall  out  1  hazard detected this cycle
- PC_write  out  1  PC register enable (= !stall)
- IFID_write  out  1  IF/ID register enable (= !stall)
- IDEX_bubble  out  1  load a NOP into ID/EX (= stall)
- stall_count  out  CNT_W  number of stalled cycles since reset, wraps

## Operation
- Scoreboard: 32 entries, index = register number. Each entry holds valid, age (2 bits: 1 = in EX, 2 = in MEM, 3 = in WB) and kind (the 2-bit RegSrc).
- Entry 0 is never valid.
- Issue: issue = ID_valid && !stall && ID_RegWrite && ID_WriteReg != 0. At the clock edge on issue, entry[ID_WriteReg] is set to {valid=1, age=1, kind=ID_RegSrc}.
- Aging: at every edge, every other valid entry advances its age 1→2→3. An entry at age 3 becomes invalid.
- Aging is unconditional, because stages after ID never stall and a stall inserts a bubble into EX.
- Same register, issue and aging on the same edge: the issue write wins, because the youngest producer shadows older ones.
- useAtID = ID_Branch != BRANCH_NONE || ID_Jump == JUMP_REG.
- Per-operand hazard, for operand r (rs gated by ID_useRs, rt gated by ID_useRt), r != 0, entry[r] valid:
  - useAtID: hazard if (age==1 && kind∈{ALU,DMEM}) or (age==2 && kind==DMEM).
  - otherwise: hazard if age==1 && kind==DMEM (load-use).
  - age 3 never causes a hazard; the register file writes through in WB.
  - kind PCPLUS4 never causes a hazard.
- stall = ID_valid && (hazard_rs || hazard_rt). stall is combinational from the scoreboard state and the ID inputs.
- Unused encodings: kind 2'b11 is treated as ALU. Any other ID_Jump value is treated as not using a register at ID.
- stall_count increments by 1 at each edge where stall=1, and wraps from all-ones to 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - all entries invalid and stall_count=0;
  - therefore stall=0, PC_write=1, IFID_write=1, IDEX_bubble=0 while rst=1.
- Reset mid-operation discards all in-flight records. The first cycle after reset sees no hazards.
- Stall decision has zero latency: outputs are valid in the same cycle as the ID inputs.
- A scoreboard update becomes visible one cycle after the issuing edge.
- Stall lengths:
  - load → dependent branch: 2 stall cycles.
  - ALU → dependent branch: 1 stall cycle.
  - load → dependent ALU op: 1 stall cycle.
  - ALU → dependent ALU op: 0 stall cycles.
- While stalled, the held ID instruction is re-evaluated every cycle. It issues on the first cycle with stall=0.
- Simultaneous hazards on rs and rt produce a single stall, counted once.

## Structure
- Shared defines file (existing control encodings): BRANCH_NONE, JUMP_REG, REGSRC_ALU, REGSRC_DMEM, REGSRC_PCPLUS4.
- New constants to add there: AGE_EX=1, AGE_MEM=2, AGE_WB=3.
- One sub-module: hazard_sb_check. It is purely combinational: (entry, useAtID, use, r) → hazard. It is instantiated twice, once for rs and once for rt.
- The scoreboard array, aging logic and performance counter live in the top module.

## Test plan
- lw $2; beq $2,$3 issued back to back → stall=1 for exactly 2 cycles, beq issues on cycle 3, stall_count=2.
- add $4; jr $4 → 1 stall cycle. add $4; nop; jr $4 → 0 stall cycles.
- lw $5; sub $6,$5,$7 → 1 stall cycle; IDEX_bubble=1 in that cycle. jal (PCPLUS4, writes $31); jr $31 → 0 stall cycles.
- Writes to $0 (lw $0; beq $0,$0) → 0 stall cycles, and entry 0 stays invalid.
- Shadowing: lw $8 then addi $8 then beq $8 → the beq stall depends only on the addi record (1 stall cycle). The older load in MEM is ignored.
- Assert rst while a load record is at age 1 → stall drops to 0 immediately and stall_count=0. After release, a dependent beq issues with no stall. Stall 2^CNT_W times → stall_count wraps to 0.
